// File: rtl/lh_pkg.sv
// Shared definitions for the light-hash sequential core: initial vector,
// ASCII class bounds for the optional character filter, FSM state type and
// small byte helpers.
package lh_pkg;

    // Initial hash vector; digests wider than 8 bytes repeat it cyclically.
    localparam logic [7:0] LH_IV [0:7] = '{8'h34, 8'h55, 8'h0F, 8'h14,
                                           8'hDA, 8'hC4, 8'h4B, 8'hA6};

    // Accepted character classes when filtering is enabled.
    localparam logic [7:0] LH_ASCII_DIG_LO = 8'h30;
    localparam logic [7:0] LH_ASCII_DIG_HI = 8'h39;
    localparam logic [7:0] LH_ASCII_UPP_LO = 8'h41;
    localparam logic [7:0] LH_ASCII_UPP_HI = 8'h5A;
    localparam logic [7:0] LH_ASCII_LOW_LO = 8'h61;
    localparam logic [7:0] LH_ASCII_LOW_HI = 8'h7A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        OUTPUT = 2'd2
    } lh_state_e;

    // Rotate a byte left by 0..7 positions.
    function automatic logic [7:0] rotl8(input logic [7:0] b, input logic [2:0] amt);
        logic [15:0] w;
        w = {b, b} << amt;
        return w[15:8];
    endfunction

    // True for '0'-'9', 'A'-'Z' and 'a'-'z'.
    function automatic logic lh_char_ok(input logic [7:0] b);
        return ((b >= LH_ASCII_DIG_LO) && (b <= LH_ASCII_DIG_HI)) ||
               ((b >= LH_ASCII_UPP_LO) && (b <= LH_ASCII_UPP_HI)) ||
               ((b >= LH_ASCII_LOW_LO) && (b <= LH_ASCII_LOW_HI));
    endfunction

    // IV byte for hash position k (the 8-byte IV repeats for longer digests).
    function automatic logic [7:0] lh_iv_byte(input int k);
        return LH_IV[3'(k % 8)];
    endfunction

endpackage

// File: rtl/lh_sbox.sv
// Combinational AES forward S-box: one 8-bit lookup, no state.
module lh_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_data = SBOX[i_data];

endmodule

// File: rtl/light_hash_seq.sv
// Iterative light-hash core. Absorbs a framed byte stream one S-box lookup
// per cycle (ROUNDS*N_BYTES cycles per absorbed char) and presents an
// N_BYTES-byte digest, H[0] in the most significant byte.
//
// Optional feature macro: LH_CHAR_FILTER_EN. When defined, only ASCII
// alphanumerics are absorbed; other bytes complete their handshake, are
// dropped, pulse err_invalid and mark the message with digest_err. When not
// defined every byte is absorbed and both error outputs stay 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The source keeps data stable while valid && !ready; ready never
// depends combinationally on valid. Input side: ptxt_valid/ptxt_ready,
// output side: digest_valid/digest_ready.
module light_hash_seq
    import lh_pkg::*;
#(
    parameter int N_BYTES = 8,
    parameter int ROUNDS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           ptxt_char,
    input  logic                 ptxt_valid,
    input  logic                 ptxt_last,
    output logic                 ptxt_ready,
    output logic [8*N_BYTES-1:0] digest,
    output logic                 digest_valid,
    input  logic                 digest_ready,
    output logic                 digest_err,
    output logic                 err_invalid,
    output logic [1:0]           o_dbg_state
);

    localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int DW = 8 * N_BYTES;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);
    localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

    lh_state_e      r_state;
    lh_state_e      w_state_next;
    logic [7:0]     r_h [N_BYTES];
    logic [7:0]     w_h_next [N_BYTES];
    logic [7:0]     r_c;
    logic           r_last;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  w_src_idx;
    logic [RW-1:0]  r_round;
    logic           r_err_acc;
    logic           r_err_invalid;
    logic [DW-1:0]  r_digest;
    logic [DW-1:0]  w_digest_next;
    logic           w_accept;
    logic           w_char_ok;
    logic           w_step_done;
    logic [7:0]     w_sbox_in;
    logic [7:0]     w_sbox_out;
    int             w_src_int;

`ifdef LH_CHAR_FILTER_EN
    assign w_char_ok = lh_char_ok(ptxt_char);
`else
    assign w_char_ok = 1'b1;
`endif

    assign ptxt_ready  = (r_state == IDLE) && !rst;
    assign w_accept    = ptxt_valid && (r_state == IDLE) && !rst;
    assign w_step_done = (r_state == ABSORB) && (r_idx == LAST_IDX) && (r_round == LAST_RND);

    assign digest      = r_digest;
    assign digest_err  = digest_valid & r_err_acc;
    assign err_invalid = r_err_invalid;
    assign o_dbg_state = r_state;

    // Source index (i+2) mod N_BYTES; i+2 < 2*N_BYTES so one subtraction suffices.
    always_comb begin
        w_src_int = int'(r_idx) + 2;
        if (w_src_int >= N_BYTES) begin
            w_src_int = w_src_int - N_BYTES;
        end
        w_src_idx = IW'(w_src_int);
    end

    assign w_sbox_in = rotl8(r_h[w_src_idx] ^ r_c, 3'(r_idx));

    lh_sbox u_sbox (
        .i_data (w_sbox_in),
        .o_data (w_sbox_out)
    );

    // Hash state after this cycle: one in-place byte update while absorbing.
    always_comb begin
        for (int k = 0; k < N_BYTES; k++) begin
            w_h_next[k] = r_h[k];
        end
        if (r_state == ABSORB) begin
            w_h_next[r_idx] = w_sbox_out;
        end
    end

    // Pack the post-update hash state, H[0] in the top byte.
    always_comb begin
        w_digest_next = '0;
        for (int k = 0; k < N_BYTES; k++) begin
            w_digest_next[DW-8-8*k +: 8] = w_h_next[k];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and digest_valid.
    always_comb begin
        w_state_next = r_state;
        digest_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_char_ok) begin
                        w_state_next = ABSORB;
                    end else if (ptxt_last) begin
                        w_state_next = OUTPUT;
                    end
                end
            end
            ABSORB: begin
                if (w_step_done) begin
                    w_state_next = r_last ? OUTPUT : IDLE;
                end
            end
            OUTPUT: begin
                digest_valid = !rst;
                if (digest_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: char latch, hash state, step counters, error flags, digest register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_BYTES; k++) begin
                r_h[k] <= lh_iv_byte(k);
            end
            r_c           <= '0;
            r_last        <= 1'b0;
            r_idx         <= '0;
            r_round       <= '0;
            r_err_acc     <= 1'b0;
            r_err_invalid <= 1'b0;
            r_digest      <= '0;
        end else begin
            r_err_invalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_c    <= ptxt_char;
                        r_last <= ptxt_last;
                        if (!w_char_ok) begin
                            r_err_acc     <= 1'b1;
                            r_err_invalid <= 1'b1;
                        end
                    end
                end
                ABSORB: begin
                    for (int k = 0; k < N_BYTES; k++) begin
                        r_h[k] <= w_h_next[k];
                    end
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_round <= (r_round == LAST_RND) ? '0 : r_round + 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (digest_ready) begin
                        for (int k = 0; k < N_BYTES; k++) begin
                            r_h[k] <= lh_iv_byte(k);
                        end
                        r_err_acc <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Capture the digest as the FSM enters OUTPUT; it then holds until the next message.
            if ((w_state_next == OUTPUT) && (r_state != OUTPUT)) begin
                r_digest <= w_digest_next;
            end
        end
    end

endmodule

// File: tb/tb_light_hash_seq.sv
// Directed bench for light_hash_seq: a default (8 bytes, 32 rounds) instance
// and a small (4 bytes, 3 rounds) instance. Expected digests come from a
// behavioural model whose S-box is derived from GF(2^8) inversion plus the
// AES affine map. Honours LH_CHAR_FILTER_EN the same way as the design.
`timescale 1ns/1ps
module tb_light_hash_seq;

`ifdef LH_CHAR_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam logic [127:0] IV_PACK = 128'h3455_0F14_DAC4_4BA6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [7:0]  b_char, s_char;
    logic        b_valid, b_last, b_ready, s_valid, s_last, s_ready;
    logic [63:0] b_digest;
    logic [31:0] s_digest;
    logic        b_dvalid, b_dready, b_derr, b_inv, s_dvalid, s_dready, s_derr, s_inv;
    logic [1:0]  b_dbg, s_dbg;

    light_hash_seq #(.N_BYTES(8), .ROUNDS(32)) u_dut (
        .clk(clk), .rst(rst), .ptxt_char(b_char), .ptxt_valid(b_valid), .ptxt_last(b_last),
        .ptxt_ready(b_ready), .digest(b_digest), .digest_valid(b_dvalid), .digest_ready(b_dready),
        .digest_err(b_derr), .err_invalid(b_inv), .o_dbg_state(b_dbg)
    );

    light_hash_seq #(.N_BYTES(4), .ROUNDS(3)) u_small (
        .clk(clk), .rst(rst), .ptxt_char(s_char), .ptxt_valid(s_valid), .ptxt_last(s_last),
        .ptxt_ready(s_ready), .digest(s_digest), .digest_valid(s_dvalid), .digest_ready(s_dready),
        .digest_err(s_derr), .err_invalid(s_inv), .o_dbg_state(s_dbg)
    );

    // Observation mux: tasks act on whichever instance use_small selects.
    logic         use_small;
    logic         m_ready, m_dvalid, m_derr;
    logic [127:0] m_digest;
    always_comb begin
        m_ready  = use_small ? s_ready  : b_ready;
        m_dvalid = use_small ? s_dvalid : b_dvalid;
        m_derr   = use_small ? s_derr   : b_derr;
        m_digest = use_small ? {96'd0, s_digest} : {64'd0, b_digest};
    end

    // Event monitors on the default instance.
    int inv_cnt = 0;
    int dvalid_cnt = 0;
    always @(negedge clk) begin
        if (b_inv) inv_cnt++;
        if (b_dvalid) dvalid_cnt++;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_bad = 0;
    logic [127:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_tb [256];
    logic [7:0] iv_tb [8] = '{8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC4, 8'h4B, 8'hA6};
    logic [7:0] msg_buf [16];
    int         msg_len;
    int         last_waits [16];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl_tb(input logic [7:0] t, input int a);
        int v;
        v = int'(t);
        v = ((v << a) | (v >> (8 - a))) & 255;
        return 8'(v);
    endfunction

    function automatic bit char_ok_tb(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_tb[v] = inv ^ rotl_tb(inv, 1) ^ rotl_tb(inv, 2) ^ rotl_tb(inv, 3)
                         ^ rotl_tb(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model(input int nb, input int rounds, input bit filt);
        logic [7:0]   h [16];
        logic [7:0]   c, t;
        logic [127:0] res;
        for (int k = 0; k < nb; k++) h[k] = iv_tb[k % 8];
        for (int m = 0; m < msg_len; m++) begin
            c = msg_buf[m];
            if (!filt || char_ok_tb(c)) begin
                for (int r = 0; r < rounds; r++) begin
                    for (int i = 0; i < nb; i++) begin
                        t = h[(i + 2) % nb] ^ c;
                        t = rotl_tb(t, i % 8);
                        h[i] = sbox_tb[t];
                    end
                end
            end
        end
        res = '0;
        for (int k = 0; k < nb; k++) res = (res << 8) | 128'(h[k]);
        return res;
    endfunction

    task automatic set_msg(input string s);
        for (int k = 0; k < s.len(); k++) msg_buf[k] = s[k];
        msg_len = s.len();
    endtask

    // ---------------- driver tasks (enter and leave at posedge+1) ----------------
    task automatic drive(input logic [7:0] c, input logic v, input logic l);
        if (use_small) begin s_char = c; s_valid = v; s_last = l; end
        else begin b_char = c; b_valid = v; b_last = l; end
    endtask

    task automatic set_dready(input logic v);
        if (use_small) s_dready = v;
        else b_dready = v;
    endtask

    task automatic send_byte(input logic [7:0] c, input bit last, output int waited);
        waited = 0;
        drive(c, 1'b1, last);
        @(negedge clk);
        while (!m_ready && waited < 3000) begin
            waited++;
            @(negedge clk);
        end
        check_eq("accept_ready", m_ready, 1);
        @(posedge clk); #1;
        drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_msg(input bit last_end);
        for (int m = 0; m < msg_len; m++) begin
            send_byte(msg_buf[m], last_end && (m == msg_len - 1), last_waits[m]);
        end
    endtask

    // Leaves the bench at the negedge where digest_valid is first seen.
    task automatic wait_valid(input int exp_lat, input string tag);
        int n, rdy;
        n = 0; rdy = 0;
        @(negedge clk);
        while (!m_dvalid && n < 3000) begin
            n++;
            if (m_ready) rdy++;
            @(negedge clk);
        end
        check_eq({tag, "_latency"}, n, exp_lat);
        check_eq({tag, "_ready_low"}, rdy, 0);
    endtask

    // Called at a negedge with digest_valid high.
    task automatic take_digest(input logic exp_err, input string tag);
        logic [127:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'b1}};
        check_eq({tag, "_digest"}, m_digest, exp);
        check_eq({tag, "_err"}, m_derr, exp_err);
        @(posedge clk); #1;
        set_dready(1'b1);
        @(posedge clk); #1;
        set_dready(1'b0);
        @(negedge clk);
        check_eq({tag, "_valid_drop"}, m_dvalid, 0);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    logic [127:0] exp_a, exp_s;
    int inv0, dv0, unstable;

    initial begin
        use_small = 1'b0;
        rst = 1'b1;
        b_char = '0; b_valid = 0; b_last = 0; b_dready = 0;
        s_char = '0; s_valid = 0; s_last = 0; s_dready = 0;
        build_sbox();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", b_ready, 0);
        check_eq("rst_dvalid", b_dvalid, 0);
        check_eq("rst_digest", b_digest, 0);
        check_eq("rst_state", b_dbg, 0);
        check_eq("rst_small_ready", s_ready, 0);
        check_eq("rst_small_state", s_dbg, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", b_ready, 1);
        @(posedge clk); #1;

        // 1: single "A" with last
        set_msg("A");
        exp_a = model(8, 32, FILT);
        exp_q.push_back(exp_a);
        send_msg(1'b1);
        wait_valid(256, "t1");
        take_digest(1'b0, "t1");

        // 2: "Hello123" with consumer stalled for 20 cycles
        set_msg("Hello123");
        exp_q.push_back(model(8, 32, FILT));
        send_msg(1'b1);
        wait_valid(256, "t2");
        unstable = 0;
        repeat (20) begin
            @(negedge clk);
            if (b_dvalid !== 1'b1 || m_digest !== exp_q[0]) unstable++;
        end
        check_eq("t2_hold_stable", unstable, 0);
        take_digest(1'b0, "t2");

        // 3: "a$b" -- '$' is dropped only when filtering
        inv0 = inv_cnt;
        set_msg("a$b");
        exp_q.push_back(model(8, 32, FILT));
        send_msg(1'b1);
        wait_valid(256, "t3");
        take_digest(FILT, "t3");
        check_eq("t3_invalid_pulses", inv_cnt - inv0, FILT);

        // 4: single 8'h00 with last
        inv0 = inv_cnt;
        msg_buf[0] = 8'h00;
        msg_len = 1;
        exp_q.push_back(FILT ? IV_PACK : model(8, 32, 1'b0));
        send_msg(1'b1);
        wait_valid(FILT ? 0 : 256, "t4");
        take_digest(FILT, "t4");
        check_eq("t4_invalid_pulses", inv_cnt - inv0, FILT);

        // 5: reset in the middle of absorbing
        set_msg("A");
        send_msg(1'b1);
        dv0 = dvalid_cnt;
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t5_rst_ready", b_ready, 0);
        check_eq("t5_rst_state", b_dbg, 0);
        check_eq("t5_rst_digest", b_digest, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check_eq("t5_no_digest", dvalid_cnt - dv0, 0);
        exp_q.push_back(exp_a);
        send_msg(1'b1);
        wait_valid(256, "t5");
        take_digest(1'b0, "t5");

        // 6: small instance, "xyz" twice back-to-back
        use_small = 1'b1;
        set_msg("xyz");
        exp_s = model(4, 3, FILT);
        exp_q.push_back(exp_s);
        send_msg(1'b1);
        check_eq("t6_wait_c0", last_waits[0], 0);
        check_eq("t6_wait_c1", last_waits[1], 12);
        check_eq("t6_wait_c2", last_waits[2], 12);
        wait_valid(12, "t6a");
        take_digest(1'b0, "t6a");
        exp_q.push_back(exp_s);
        send_msg(1'b1);
        check_eq("t6b_wait_c1", last_waits[1], 12);
        wait_valid(12, "t6b");
        take_digest(1'b0, "t6b");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
